// File: rtl/dwa_element_selector.sv
// Quantizes the noise-shaping filter output to a unit-element level and picks
// the enabled DAC elements with a data-weighted-averaging rotating pointer.
module dwa_element_selector #(
   parameter int IN_W      = 64,
   parameter int NUM_ELEM  = 8,
   parameter int FRAC_BITS = 12,
   parameter int CNT_W     = 16
) (
   input  logic                          clk_i,
   input  logic                          reset_i,
   input  logic                          valid_i,
   output logic                          ready_o,
   input  logic signed [IN_W-1:0]        data_i,
   output logic                          valid_o,
   input  logic                          ready_i,
   output logic [NUM_ELEM-1:0]           sel_o,
   output logic [$clog2(NUM_ELEM):0]     level_o,
   output logic signed [IN_W-1:0]        err_o,
   output logic                          sat_o,
   output logic [$clog2(NUM_ELEM)-1:0]   ptr_o,
   output logic [CNT_W-1:0]              sat_cnt_o
);

   localparam int PTR_W = $clog2(NUM_ELEM);
   localparam int LVL_W = PTR_W + 1;
   localparam logic signed [IN_W:0] HALF    = (IN_W+1)'(NUM_ELEM / 2);
   localparam logic signed [IN_W:0] LVL_MAX = (IN_W+1)'(NUM_ELEM);

   logic                     en;
   logic signed [IN_W-1:0]   shifted;
   logic signed [IN_W:0]     raw;
   logic [LVL_W-1:0]         q_lvl;
   logic                     q_sat;
   logic signed [IN_W-1:0]   q_offset;
   logic signed [IN_W-1:0]   q_err;

   logic                     s1_v;
   logic [LVL_W-1:0]         s1_lvl;
   logic                     s1_sat;
   logic signed [IN_W-1:0]   s1_err;

   logic [NUM_ELEM-1:0]      therm;
   logic [2*NUM_ELEM-1:0]    rot;
   logic [NUM_ELEM-1:0]      mask;

   assign en      = !valid_o || ready_i;
   assign ready_o = en;

   // Floor-quantize around mid-scale; the extra bit keeps the offset add from wrapping.
   always_comb begin
      shifted  = data_i >>> FRAC_BITS;
      raw      = $signed({shifted[IN_W-1], shifted}) + HALF;
      q_lvl    = raw[LVL_W-1:0];
      q_sat    = 1'b0;
      if (raw[IN_W]) begin
         q_lvl = '0;
         q_sat = 1'b1;
      end else if (raw > LVL_MAX) begin
         q_lvl = LVL_W'(NUM_ELEM);
         q_sat = 1'b1;
      end
      q_offset = IN_W'(q_lvl) - IN_W'(NUM_ELEM / 2);
      q_err    = data_i - (q_offset <<< FRAC_BITS);
   end

   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         s1_v   <= 1'b0;
         s1_lvl <= '0;
         s1_sat <= 1'b0;
         s1_err <= '0;
      end else if (en) begin
         s1_v <= valid_i;
         if (valid_i) begin
            s1_lvl <= q_lvl;
            s1_sat <= q_sat;
            s1_err <= q_err;
         end
      end
   end

   // Thermometer of lvl ones rotated left by the pointer, high half folded back for wrap.
   always_comb begin
      therm = '0;
      for (int k = 0; k < NUM_ELEM; k++) begin
         therm[k] = (LVL_W'(k) < s1_lvl);
      end
      rot  = {{NUM_ELEM{1'b0}}, therm} << ptr_o;
      mask = rot[NUM_ELEM-1:0] | rot[2*NUM_ELEM-1:NUM_ELEM];
   end

   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         valid_o   <= 1'b0;
         sel_o     <= '0;
         level_o   <= '0;
         err_o     <= '0;
         sat_o     <= 1'b0;
         ptr_o     <= '0;
         sat_cnt_o <= '0;
      end else if (en) begin
         valid_o <= s1_v;
         if (s1_v) begin
            sel_o   <= mask;
            level_o <= s1_lvl;
            err_o   <= s1_err;
            sat_o   <= s1_sat;
            ptr_o   <= ptr_o + s1_lvl[PTR_W-1:0];
            if (s1_sat && !(&sat_cnt_o)) begin
               sat_cnt_o <= sat_cnt_o + CNT_W'(1);
            end
         end
      end
   end

endmodule

// File: doc/dwa_element_selector.md
Name: dwa_element_selector

Overview:
- Downstream neighbour of the second-order notch/noise-shaping filter in the DEM-DAC path.
- Takes the filter's wide signed output and quantizes it to a unit-element level 0..NUM_ELEM.
- Applies data-weighted-averaging (DWA) rotation to choose which unit DAC elements switch on, so element mismatch is first-order shaped.
- Returns the quantization error so the loop can feed it back to the filter input.

Parameters:
- IN_W, 64: input sample width (filter output width, 4x the 16-bit base WIDTH).
- NUM_ELEM, 8: number of unit DAC elements; power of two, 2..32.
- FRAC_BITS, 12: LSB weight of one element step (one level = 2^FRAC_BITS input LSBs).
- CNT_W, 16: width of the saturation event counter.

Ports:
- clk_i  in  1  clock.
- reset_i  in  1  asynchronous, active-high reset.
- valid_i  in  1  input sample valid.
- ready_o  out  1  block can accept a sample this cycle.
- data_i  in  IN_W  signed filter output sample.
- valid_o  out  1  output word valid.
- ready_i  in  1  downstream (switch block) accepts output.
- sel_o  out  NUM_ELEM  element enable mask; bit k drives unit element k.
- level_o  out  $clog2(NUM_ELEM)+1  unsigned level = popcount(sel_o).
- err_o  out  IN_W  signed quantization error for the sample in sel_o.
- sat_o  out  1  sample in sel_o was clipped.
- ptr_o  out  $clog2(NUM_ELEM)  current DWA pointer (debug).
- sat_cnt_o  out  CNT_W  count of clipped samples; saturates at all-ones.

Behaviour:
- Reset values (asynchronous, immediate): valid_o, sel_o, level_o, err_o, sat_o, ptr_o, sat_cnt_o, and the stage-1 valid all 0. Reset mid-operation discards all in-flight samples.
- Pipeline enable: en = !valid_o || ready_i. ready_o = en, driven combinationally. The whole pipeline stalls when en=0, and all registers hold.
- A sample is accepted when valid_i && ready_o. Latency is 2 clk from acceptance to valid_o, with no downstream stall. Throughput is 1 sample per clk.
- Stage 1 (loads on en): s1_v <= valid_i.
  - raw = (data_i >>> FRAC_BITS) + NUM_ELEM/2, computed at IN_W+1 bits. The arithmetic shift floors, so -1 maps to level NUM_ELEM/2-1.
  - If raw < 0: lvl = 0, sat = 1.
  - If raw > NUM_ELEM: lvl = NUM_ELEM, sat = 1.
  - Otherwise: lvl = raw, sat = 0.
  - err = data_i - ((lvl - NUM_ELEM/2) << FRAC_BITS), truncated to IN_W.
- Stage 2 / output (loads on en): valid_o <= s1_v. When s1_v=1:
  - sel_o has bits (ptr + i) mod NUM_ELEM set for i = 0..lvl-1, and all other bits clear.
  - ptr <= (ptr + lvl) mod NUM_ELEM.
  - level_o, err_o, sat_o are registered from stage 1.
  - If sat=1, sat_cnt_o increments, holding at all-ones.
- When s1_v=0 and en=1: valid_o goes 0. sel_o, level_o, err_o, sat_o, ptr and the counter hold their values.
- Boundary cases:
  - lvl = NUM_ELEM gives an all-ones mask and leaves the pointer unchanged.
  - lvl = 0 gives a zero mask and leaves the pointer unchanged.
  - The mask wraps across bit NUM_ELEM-1 to bit 0.
  - The pointer wraps modulo NUM_ELEM.
- Outputs remain stable while valid_o && !ready_i. The pointer never advances during a stall.

Test Plan:
- Defaults used throughout. Reset, then send data_i=0 -> 2 clk later valid_o=1, level_o=4, sel_o=0x0F, err_o=0, ptr_o=4.
- Back-to-back 0, then 4096 (level 5) -> second output sel_o=0xF1 (bits 4,5,6,7,0 wrap), ptr_o=1.
- Send data_i=-40960 -> level_o=0, sel_o=0x00, sat_o=1, sat_cnt_o=1, ptr unchanged. Then send 1<<40 -> level_o=8, sel_o=0xFF, sat_cnt_o=2, ptr unchanged.
- Send data_i=-1 -> level_o=3, err_o=4095. Send data_i=6000 -> level_o=5, err_o=1904.
- Hold ready_i=0 for 5 clk with valid_i=1 streaming -> ready_o=0 after valid_o rises, outputs and ptr_o frozen. Release -> no sample lost or duplicated, order preserved.
- Assert reset_i mid-stream with 2 samples in flight -> valid_o, ptr_o, sat_cnt_o drop to 0 immediately. The first post-reset sample 0 yields sel_o=0x0F.
